seq_addsub: RTL and testbench

Multi-cycle, parametrised add/subtract unit: the sequential successor to the 32-bit ripple-carry adder in the datapath. It processes `CHUNK` bits per clock over `WIDTH/CHUNK` cycles, which trades latency for a short carry chain. It adds subtraction, carry/overflow/zero flags and a start/done handshake. It sits beside the ALU and serves multi-cycle arithmetic, such as address and offset computation, where a full-width ripple path would limit clock period.

---
 rtl/seq_addsub.sv | 148 ++++++++++++++
 tb/tb_seq_addsub.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle add/subtract unit.
// Processes CHUNK bits per clock over N = WIDTH/CHUNK cycles, which keeps the
// carry chain short. A start/done handshake frames each operation.
//
// Ports:
//   clk      in   clock, all state changes on rising edge
//   reset_n  in   synchronous active-low reset
//   start    in   request, sampled only while busy=0
//   sub      in   0 = a+b, 1 = a-b (sampled with start)
//   a, b     in   operands (sampled with start)
//   busy     out  operation in progress
//   done     out  one-cycle pulse, results valid
//   sum      out  result, held until the next accepted start
//   cout     out  carry out of MSB (subtract: 1 = no borrow)
//   ovf      out  two's-complement signed overflow
//   zero     out  sum == 0
//
// state  | meaning
// S_IDLE | waiting for start, outputs held
// S_RUN  | one chunk added per cycle, chunk index r_idx

module seq_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_done;

    logic             w_accept;
    logic             w_last;
    logic [CHUNK-1:0] w_a_chk;
    logic [CHUNK-1:0] w_b_chk;
    logic [CHUNK:0]   w_chk_sum;
    logic             w_c_msb_in;
    logic [WIDTH-1:0] w_sum_nxt;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_state == S_RUN) && (r_idx == LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (r_idx == LAST) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (r_state == S_RUN);
        done = r_done;
        sum  = r_sum;
        cout = r_cout;
        ovf  = r_ovf;
        zero = r_zero;
    end

    // Chunk adder. The carry into the chunk MSB is recovered from the MSB sum
    // bit (s = a ^ b ^ cin), which also covers CHUNK=1 where it is r_carry.
    always_comb begin
        w_a_chk    = r_a[r_idx*CHUNK +: CHUNK];
        w_b_chk    = r_b[r_idx*CHUNK +: CHUNK];
        w_chk_sum  = {1'b0, w_a_chk} + {1'b0, w_b_chk} + {{CHUNK{1'b0}}, r_carry};
        w_c_msb_in = w_a_chk[CHUNK-1] ^ w_b_chk[CHUNK-1] ^ w_chk_sum[CHUNK-1];
        w_sum_nxt  = r_sum;
        w_sum_nxt[r_idx*CHUNK +: CHUNK] = w_chk_sum[CHUNK-1:0];
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b ^ {WIDTH{sub}};
                r_carry <= sub;
                r_idx   <= '0;
                r_sum   <= '0;
                r_cout  <= 1'b0;
                r_ovf   <= 1'b0;
                r_zero  <= 1'b0;
            end else if (r_state == S_RUN) begin
                r_sum   <= w_sum_nxt;
                r_carry <= w_chk_sum[CHUNK];
                if (w_last) begin
                    r_idx  <= '0;
                    r_cout <= w_chk_sum[CHUNK];
                    r_ovf  <= w_c_msb_in ^ w_chk_sum[CHUNK];
                    r_zero <= (w_sum_nxt == '0);
                    r_done <= 1'b1;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_addsub.sv
// Testbench for seq_addsub: three instances (CHUNK=8, 1, 32) with a
// scoreboard of expected results checked whenever an instance pulses done.

module tb_seq_addsub;

    localparam int NK0 = 4;
    localparam int NK1 = 32;
    localparam int NK2 = 1;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          start_cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [2:0]       start_i = '0;
    logic [2:0]       sub_i = '0;
    logic [2:0][31:0] a_i = '0;
    logic [2:0][31:0] b_i = '0;
    logic [2:0]       busy_o;
    logic [2:0]       done_o;
    logic [2:0][31:0] sum_o;
    logic [2:0]       cout_o;
    logic [2:0]       ovf_o;
    logic [2:0]       zero_o;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_addsub #(.WIDTH(32), .CHUNK(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .start(start_i[0]), .sub(sub_i[0]),
        .a(a_i[0]), .b(b_i[0]), .busy(busy_o[0]), .done(done_o[0]),
        .sum(sum_o[0]), .cout(cout_o[0]), .ovf(ovf_o[0]), .zero(zero_o[0]));

    seq_addsub #(.WIDTH(32), .CHUNK(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start_i[1]), .sub(sub_i[1]),
        .a(a_i[1]), .b(b_i[1]), .busy(busy_o[1]), .done(done_o[1]),
        .sum(sum_o[1]), .cout(cout_o[1]), .ovf(ovf_o[1]), .zero(zero_o[1]));

    seq_addsub #(.WIDTH(32), .CHUNK(32)) u_dut32 (
        .clk(clk), .reset_n(reset_n), .start(start_i[2]), .sub(sub_i[2]),
        .a(a_i[2]), .b(b_i[2]), .busy(busy_o[2]), .done(done_o[2]),
        .sum(sum_o[2]), .cout(cout_o[2]), .ovf(ovf_o[2]), .zero(zero_o[2]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: full-width add with carry-in = sub; signed overflow from operand/result signs.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        exp_t        e;
        logic [31:0] bb;
        logic [32:0] full;
        bb     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {32'd0, sub};
        e.sum  = full[31:0];
        e.cout = full[32];
        e.ovf  = (a[31] == bb[31]) && (full[31] != a[31]);
        e.zero = (full[31:0] == 32'd0);
        e.start_cyc = 0;
        return e;
    endfunction

    function automatic int lat_of(input int k);
        case (k)
            0:       return NK0;
            1:       return NK1;
            default: return NK2;
        endcase
    endfunction

    task automatic pop_check(input int k);
        exp_t e;
        int   sz;
        case (k)
            0:       sz = q0.size();
            1:       sz = q1.size();
            default: sz = q2.size();
        endcase
        if (sz == 0) begin
            chk($sformatf("spurious_done%0d", k), 64'(sz), 64'd1);
        end else begin
            case (k)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            chk($sformatf("sum%0d", k),  64'(sum_o[k]),  64'(e.sum));
            chk($sformatf("cout%0d", k), 64'(cout_o[k]), 64'(e.cout));
            chk($sformatf("ovf%0d", k),  64'(ovf_o[k]),  64'(e.ovf));
            chk($sformatf("zero%0d", k), 64'(zero_o[k]), 64'(e.zero));
            chk($sformatf("busy_at_done%0d", k), 64'(busy_o[k]), 64'd0);
            chk($sformatf("latency%0d", k), 64'(cyc - e.start_cyc), 64'(lat_of(k)));
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (done_o[k] === 1'b1) pop_check(k);
        end
    end

    // Drive start at the current negedge; returns at the next negedge with start low.
    task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input bit push);
        exp_t e;
        a_i[k]     = a;
        b_i[k]     = b;
        sub_i[k]   = sub;
        start_i[k] = 1'b1;
        if (push) begin
            e = model(a, b, sub);
            e.start_cyc = cyc + 1;
            case (k)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
        @(negedge clk);
        start_i[k] = 1'b0;
    endtask

    task automatic wait_done(input int k);
        int n = 0;
        while (done_o[k] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk($sformatf("done_timeout%0d", k), 64'(done_o[k]), 64'd1);
    endtask

    task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b, input logic sub);
        issue(k, a, b, sub, 1'b1);
        wait_done(k);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy_o[0]), 64'd0);
        chk("rst_done", 64'(done_o[0]), 64'd0);
        chk("rst_sum",  64'(sum_o[0]),  64'd0);
        chk("rst_flags", 64'({cout_o[0], ovf_o[0], zero_o[0]}), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_op(0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        @(negedge clk);
        chk("hold_sum",  64'(sum_o[0]),  64'd0);
        chk("hold_zero", 64'(zero_o[0]), 64'd1);
        chk("hold_done", 64'(done_o[0]), 64'd0);

        // Consecutive run_op calls start on the done cycle (back-to-back).
        run_op(0, 32'h7FFF_FFFF, 32'd1, 1'b0);
        run_op(0, 32'h8000_0000, 32'd1, 1'b1);
        run_op(0, 32'd5, 32'd7, 1'b1);
        run_op(0, 32'd7, 32'd7, 1'b1);
        @(negedge clk);

        // Start during RUN with other operands is ignored.
        issue(0, 32'h1234_5678, 32'h0000_1111, 1'b0, 1'b1);
        @(negedge clk);
        issue(0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 1'b0);
        wait_done(0);
        @(negedge clk);

        // Reset at cycle 2 of RUN aborts; outputs previously nonzero must clear.
        run_op(0, 32'd9, 32'd9, 1'b1);
        @(negedge clk);
        issue(0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy_o[0]), 64'd0);
        chk("abort_sum",  64'(sum_o[0]),  64'd0);
        chk("abort_done", 64'(done_o[0]), 64'd0);
        chk("abort_flags", 64'({cout_o[0], ovf_o[0], zero_o[0]}), 64'd0);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        run_op(0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
        @(negedge clk);

        for (int k = 1; k < 3; k++) begin
            for (int i = 0; i < 1000; i++) begin
                run_op(k, $urandom, $urandom, 1'($urandom_range(0, 1)));
            end
            @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("q0_empty", 64'(q0.size()), 64'd0);
        chk("q1_empty", 64'(q1.size()), 64'd0);
        chk("q2_empty", 64'(q2.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
